// File: rtl/instr_loader_pkg.sv
// -----------------------------------------------------------------------------
// instr_loader_pkg
//   Shared types and constants for the instruction-memory loader.
//   - state_t        : loader FSM states (CHECK is only reachable when the
//                      INSTR_LOADER_CHECKSUM_EN build option is defined)
//   - BYTES_PER_WORD : host bytes packed into one 32-bit instruction word
//   - lane_t         : byte-lane index inside a word
// -----------------------------------------------------------------------------
package instr_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int LANE_W         = $clog2(BYTES_PER_WORD);

  typedef logic [LANE_W-1:0] lane_t;

  localparam lane_t LAST_LANE = lane_t'(BYTES_PER_WORD - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage : instr_loader_pkg

// File: rtl/instr_loader_if.sv
// -----------------------------------------------------------------------------
// instr_loader_if
//   Host byte-stream link (valid/ready) into the instruction loader.
//   Signals:
//     byte_valid : host has a byte available      (host -> loader)
//     byte_data  : the byte                       (host -> loader)
//     byte_ready : loader takes the byte this cycle when byte_valid is high
//                                                 (loader -> host)
//   Modports:
//     master : the host side
//     slave  : the loader side
// -----------------------------------------------------------------------------
interface instr_loader_if;

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;

  modport master (output byte_valid, output byte_data, input  byte_ready);
  modport slave  (input  byte_valid, input  byte_data, output byte_ready);

endinterface : instr_loader_if

// File: rtl/byte_packer.sv
// -----------------------------------------------------------------------------
// byte_packer
//   Packs a byte stream little-endian into 32-bit words: the first byte of a
//   word lands in bits [7:0], the fourth in bits [31:24].
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     clear       : synchronous restart at lane 0 (new load)
//     take        : a byte is transferred this cycle
//     byte_data   : the byte being transferred
//     word_valid  : this transfer completes a word (combinational)
//     word        : the completed word, valid together with word_valid
// -----------------------------------------------------------------------------
module byte_packer
  import instr_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        take,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  lane_t       lane_q;
  // Lanes 0..2 are held here; lane 3 is taken straight from the input so the
  // finished word is available in the same cycle as its last byte.
  logic [23:0] low_q;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before the clock edge, regardless of statement
  // order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q <= '0;
      low_q  <= '0;
    end else if (clear) begin
      lane_q <= '0;
    end else if (take) begin
      // Lane counter wraps 3 -> 0 naturally at its 2-bit width.
      lane_q <= lane_q + lane_t'(1);
      case (lane_q)
        lane_t'(0): low_q[7:0]   <= byte_data;
        lane_t'(1): low_q[15:8]  <= byte_data;
        lane_t'(2): low_q[23:16] <= byte_data;
        default:    ;
      endcase
    end
  end

  assign word_valid = take && (lane_q == LAST_LANE);
  assign word       = {byte_data, low_q};

endmodule : byte_packer

// File: rtl/instr_loader.sv
// -----------------------------------------------------------------------------
// instr_loader
//   Writer side of the instruction memory. Accepts bytes from the host link,
//   packs them little-endian into 32-bit words and writes them to consecutive
//   word addresses starting at 0. Holds the CPU in reset while loading.
//
//   Build option: INSTR_LOADER_CHECKSUM_EN
//     Defined   : after the data, one extra byte is accepted and compared with
//                 the XOR of all data bytes; err reports a mismatch and keeps
//                 the CPU held in reset.
//     Undefined : no checksum byte, err is tied low.
//
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     start      : request a load (sampled only in IDLE)
//     len        : words to load, saturated to 2**ADDRESS_WIDTH
//     host       : byte-stream link (instr_loader_if.slave)
//     WE/WA/WD   : instruction RAM write port (WA/WD hold while WE=0)
//     busy       : load in progress
//     done       : one-cycle completion pulse
//     cpu_rst    : active-high CPU reset hold
//     err        : checksum mismatch of the last load
// -----------------------------------------------------------------------------
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 12,
  parameter int DATA_WIDTH    = 32  // must be 32: four bytes per word
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH:0]   len,
  instr_loader_if.slave            host,
  output logic                     WE,
  output logic [ADDRESS_WIDTH-1:0] WA,
  output logic [DATA_WIDTH-1:0]    WD,
  output logic                     busy,
  output logic                     done,
  output logic                     cpu_rst,
  output logic                     err
);

  localparam logic [ADDRESS_WIDTH:0] MAX_LEN = {1'b1, {ADDRESS_WIDTH{1'b0}}};
  localparam logic [ADDRESS_WIDTH:0] ONE     = {{ADDRESS_WIDTH{1'b0}}, 1'b1};

  state_t                 state_q;
  logic                   byte_ready_q;
  logic [ADDRESS_WIDTH:0] len_q;
  // One bit wider than WA so a full-depth load ends at 2**ADDRESS_WIDTH
  // without aliasing back to address 0.
  logic [ADDRESS_WIDTH:0] word_cnt_q;

  logic [ADDRESS_WIDTH:0] len_sat;
  logic                   start_ok;
  logic                   take;
  logic                   word_valid;
  logic [31:0]            word;
  logic                   last_word;

  assign len_sat   = (len > MAX_LEN) ? MAX_LEN : len;
  assign start_ok  = (state_q == IDLE) && start;
  assign take      = host.byte_valid && byte_ready_q && (state_q == LOAD);
  assign last_word = (word_cnt_q == len_q - ONE);

  assign host.byte_ready = byte_ready_q;

  byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (start_ok),
    .take       (take),
    .byte_data  (host.byte_data),
    .word_valid (word_valid),
    .word       (word)
  );

`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0] xor_q;
  logic       ck_take;
  logic       ck_bad;

  assign ck_take = host.byte_valid && byte_ready_q && (state_q == CHECK);
  assign ck_bad  = (host.byte_data != xor_q);
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      byte_ready_q <= 1'b0;
      len_q        <= '0;
      word_cnt_q   <= '0;
      WE           <= 1'b0;
      WA           <= '0;
      WD           <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      cpu_rst      <= 1'b1;
`ifdef INSTR_LOADER_CHECKSUM_EN
      xor_q        <= '0;
      err          <= 1'b0;
`endif
    end else begin
      // Pulsed outputs fall back low unless re-asserted below.
      WE   <= 1'b0;
      done <= 1'b0;

      case (state_q)
        IDLE: begin
          if (start) begin
            len_q      <= len_sat;
            word_cnt_q <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            xor_q      <= '0;
            err        <= 1'b0;
`endif
            if (len_sat == '0) begin
              state_q <= DONE;
              done    <= 1'b1;
              cpu_rst <= 1'b0;
            end else begin
              state_q      <= LOAD;
              byte_ready_q <= 1'b1;
              busy         <= 1'b1;
              cpu_rst      <= 1'b1;
            end
          end
        end

        LOAD: begin
          if (take) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
            xor_q <= xor_q ^ host.byte_data;
`endif
            if (word_valid) begin
              WE         <= 1'b1;
              WA         <= word_cnt_q[ADDRESS_WIDTH-1:0];
              WD         <= DATA_WIDTH'(word);
              word_cnt_q <= word_cnt_q + ONE;
              if (last_word) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                // byte_ready stays high for the checksum byte.
                state_q      <= CHECK;
`else
                state_q      <= DONE;
                byte_ready_q <= 1'b0;
                busy         <= 1'b0;
                done         <= 1'b1;
                cpu_rst      <= 1'b0;
`endif
              end
            end
          end
        end

`ifdef INSTR_LOADER_CHECKSUM_EN
        CHECK: begin
          if (ck_take) begin
            state_q      <= DONE;
            byte_ready_q <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b1;
            err          <= ck_bad;
            cpu_rst      <= ck_bad;
          end
        end
`endif

        DONE: begin
          state_q <= IDLE;
        end

        default: begin
          state_q      <= IDLE;
          byte_ready_q <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule : instr_loader
